// File: rtl/align_stage_sequencer.sv
// Top-level sequencer for the alignment pipeline: releases stages one at a time,
// runs batches of jobs, and guards each stage with a watchdog.
module align_stage_sequencer #(
  parameter  int unsigned NUM_STAGES  = 4,
  parameter  int unsigned JOB_W       = 8,
  parameter  int unsigned TIMEOUT_CYC = 4096,
  localparam int unsigned SW          = $clog2(NUM_STAGES),
  localparam int unsigned TW          = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  start,
  input  logic [JOB_W-1:0]      num_jobs,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_flag,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  job_load,
  output logic [SW-1:0]         cur_stage,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [SW-1:0]         err_stage,
  output logic [JOB_W-1:0]      jobs_done
);

  typedef enum logic [2:0] {
    st_idle,
    st_load,
    st_run,
    st_done,
    st_err
  } state_t;

  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);
  localparam logic [TW-1:0] TIMER_LIM  = TW'(TIMEOUT_CYC - 1);

  state_t                  state, state_nxt;
  logic [TW-1:0]           timer, timer_nxt;
  logic [JOB_W-1:0]        target, target_nxt;
  logic [JOB_W-1:0]        jobs_nxt, jobs_inc;
  logic [SW-1:0]           cur_nxt, err_stage_nxt;
  logic                    err_nxt;
  logic [NUM_STAGES-1:0]   stage_rst_nxt;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state     <= st_idle;
      timer     <= '0;
      target    <= '0;
      jobs_done <= '0;
      cur_stage <= '0;
      err       <= 1'b0;
      err_stage <= '0;
      stage_rst <= '1;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      target    <= target_nxt;
      jobs_done <= jobs_nxt;
      cur_stage <= cur_nxt;
      err       <= err_nxt;
      err_stage <= err_stage_nxt;
      stage_rst <= stage_rst_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    target_nxt    = target;
    jobs_nxt      = jobs_done;
    cur_nxt       = cur_stage;
    err_nxt       = err;
    err_stage_nxt = err_stage;
    stage_rst_nxt = stage_rst;
    jobs_inc      = jobs_done + JOB_W'(1);

    if (abort && (state != st_idle)) begin
      state_nxt = st_idle;
    end else begin
      unique case (state)
        st_idle: begin
          if (start) begin
            state_nxt  = st_load;
            target_nxt = (num_jobs == '0) ? JOB_W'(1) : num_jobs;
            jobs_nxt   = '0;
            err_nxt    = 1'b0;
          end
        end
        st_load: state_nxt = st_run;
        st_run: begin
          if (stage_flag[cur_stage]) begin
            if (cur_stage != LAST_STAGE) begin
              cur_nxt   = cur_stage + SW'(1);
              timer_nxt = '0;
            end else begin
              jobs_nxt  = jobs_inc;
              state_nxt = (jobs_inc == target) ? st_done : st_load;
            end
          end else if (timer == TIMER_LIM) begin
            state_nxt     = st_err;
            err_nxt       = 1'b1;
            err_stage_nxt = cur_stage;
          end else begin
            timer_nxt = timer + TW'(1);
          end
        end
        st_done: state_nxt = st_idle;
        st_err:  state_nxt = st_idle;
        default: state_nxt = st_idle;
      endcase
    end

    // stage_rst is registered from the next state so it lines up with that state's cycle
    unique case (state_nxt)
      st_load: begin
        stage_rst_nxt = '1;
        cur_nxt       = '0;
        timer_nxt     = '0;
      end
      st_run: begin
        for (int unsigned j = 0; j < NUM_STAGES; j++) begin
          stage_rst_nxt[j] = (j > 32'(cur_nxt));
        end
      end
      st_done: stage_rst_nxt = '0;
      st_err:  stage_rst_nxt = '1;
      default: begin
        if (abort && (state != st_idle)) stage_rst_nxt = '1;
      end
    endcase
  end

  assign job_load = (state == st_load);
  assign busy     = (state == st_load) || (state == st_run);
  assign done     = (state == st_done) && !abort;

endmodule

// File: tb/tb_align_stage_sequencer.sv
// Scoreboard bench for align_stage_sequencer: stage models answer released stages,
// batch outcomes are queued at start and matched when done/err appear.
module tb_align_stage_sequencer;

  logic       CLK;
  logic       rst;
  logic       start;
  logic [7:0] num_jobs;
  logic       abort;
  logic [3:0] stage_flag;
  logic [3:0] stage_rst;
  logic       job_load;
  logic [1:0] cur_stage;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_stage;
  logic [7:0] jobs_done;

  align_stage_sequencer #(
    .NUM_STAGES (4),
    .JOB_W      (8),
    .TIMEOUT_CYC(20)
  ) dut (
    .CLK       (CLK),
    .rst       (rst),
    .start     (start),
    .num_jobs  (num_jobs),
    .abort     (abort),
    .stage_flag(stage_flag),
    .stage_rst (stage_rst),
    .job_load  (job_load),
    .cur_stage (cur_stage),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_stage (err_stage),
    .jobs_done (jobs_done)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] jobs;
    logic [1:0] stg;
  } sb_t;

  sb_t        sb[$];
  logic [3:0] seq[$];
  int         checks = 0;
  int         errors = 0;
  int         loads = 0;
  int         done_cnt = 0;
  int         lat[4];
  int         cnt[4];
  logic [3:0] mflag;
  logic [3:0] frc;
  logic       err_prev = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign stage_flag = mflag | frc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stage model: flag rises lat[j] cycles after release, held while released (lat 0 = never)
  always @(posedge CLK) begin
    for (int j = 0; j < 4; j++) begin
      if (stage_rst[j]) begin
        cnt[j]   <= 0;
        mflag[j] <= 1'b0;
      end else begin
        cnt[j]   <= cnt[j] + 1;
        mflag[j] <= (lat[j] != 0) && (cnt[j] + 1 >= lat[j]);
      end
    end
  end

  always @(negedge CLK) begin
    sb_t e;
    if (job_load) begin
      loads++;
      chk("load_stage_rst", stage_rst, 4'hF);
      chk("load_cur_stage", cur_stage, 0);
    end
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) chk("sb_unexpected_done", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("done_kind", e.is_err, 0);
        chk("done_jobs_done", jobs_done, e.jobs);
        chk("done_stage_rst", stage_rst, 4'h0);
      end
    end
    if (err && !err_prev) begin
      if (sb.size() == 0) chk("sb_unexpected_err", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("err_kind", e.is_err, 1);
        chk("err_stage", err_stage, e.stg);
      end
    end
    err_prev = err;
  end

  task automatic run_batch(input logic [7:0] n, input int exp_jobs, input bit poke);
    int l0, d0, cyc;
    logic [3:0] last;
    seq.delete();
    l0 = loads;
    d0 = done_cnt;
    @(negedge CLK);
    num_jobs = n;
    start = 1'b1;
    sb.push_back('{1'b0, 8'(exp_jobs), 2'd0});
    @(negedge CLK);
    start = 1'b0;
    last = 'x;
    for (cyc = 0; cyc < 1000; cyc++) begin
      if (stage_rst !== last) begin
        seq.push_back(stage_rst);
        last = stage_rst;
      end
      if (poke && cyc == 8) begin
        start = 1'b1;
        num_jobs = 8'd7;
      end
      if (cyc == 9) begin
        start = 1'b0;
        num_jobs = n;
      end
      if (done) break;
      @(negedge CLK);
    end
    @(negedge CLK);
    chk("batch_done_pulses", done_cnt - d0, 1);
    chk("batch_job_loads", loads - l0, exp_jobs);
    chk("batch_busy_after", busy, 0);
    chk("batch_jobs_done", jobs_done, exp_jobs);
    chk("batch_err", err, 0);
  endtask

  task automatic check_seq();
    logic [3:0] exp_seq[5];
    exp_seq = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    chk("seq_len", seq.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < seq.size()) chk("seq_stage_rst", seq[i], exp_seq[i]);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_stage_rst"}, stage_rst, 4'hF);
    chk({pfx, "_job_load"}, job_load, 0);
    chk({pfx, "_cur_stage"}, cur_stage, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_err"}, err, 0);
    chk({pfx, "_err_stage"}, err_stage, 0);
    chk({pfx, "_jobs_done"}, jobs_done, 0);
  endtask

  initial begin
    int cyc, rel, d0, l0;
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    num_jobs = '0;
    frc = '0;
    lat = '{3, 5, 2, 4};
    repeat (2) @(negedge CLK);
    check_reset_vals("reset");
    rst = 1'b1;

    // Single job, then a batch of three with a start poked while busy, then num_jobs=0
    run_batch(8'd1, 1, 1'b0);
    check_seq();
    run_batch(8'd3, 3, 1'b1);
    run_batch(8'd0, 1, 1'b0);
    check_seq();

    // Stage 2 hangs: watchdog fires 20 cycles after its release
    lat[2] = 0;
    d0 = done_cnt;
    @(negedge CLK);
    num_jobs = 8'd1;
    start = 1'b1;
    sb.push_back('{1'b1, 8'd0, 2'd2});
    @(negedge CLK);
    start = 1'b0;
    rel = -1;
    for (cyc = 0; cyc < 200; cyc++) begin
      if (rel < 0 && stage_rst == 4'b1000) rel = cyc;
      if (err) break;
      @(negedge CLK);
    end
    chk("err_latency", cyc - rel, 20);
    chk("err_cycle_stage_rst", stage_rst, 4'hF);
    chk("err_cycle_busy", busy, 0);
    @(negedge CLK);
    chk("err_sticky", err, 1);
    chk("err_idle_stage_rst", stage_rst, 4'hF);
    chk("err_no_done", done_cnt - d0, 0);
    lat[2] = 2;

    // Abort in stage 1 coinciding with its flag; start poked while busy
    lat[1] = 0;
    d0 = done_cnt;
    l0 = loads;
    @(negedge CLK);
    num_jobs = 8'd1;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("start_clears_err", err, 0);
    for (cyc = 0; cyc < 200; cyc++) begin
      if (cyc == 2) begin
        start = 1'b1;
        num_jobs = 8'd9;
      end
      if (cyc == 3) begin
        start = 1'b0;
        num_jobs = 8'd1;
      end
      if (busy && cur_stage == 2'd1) break;
      @(negedge CLK);
    end
    frc[1] = 1'b1;
    abort = 1'b1;
    @(negedge CLK);
    frc = '0;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_stage_rst", stage_rst, 4'hF);
    chk("abort_err", err, 0);
    repeat (5) @(negedge CLK);
    chk("abort_stays_idle", busy, 0);
    chk("abort_loads", loads - l0, 1);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_jobs_done", jobs_done, 0);
    lat[1] = 5;

    // Asynchronous reset in the middle of the second job of a batch
    l0 = loads;
    @(negedge CLK);
    num_jobs = 8'd3;
    start = 1'b1;
    sb.push_back('{1'b0, 8'd3, 2'd0});
    @(negedge CLK);
    start = 1'b0;
    for (cyc = 0; cyc < 300; cyc++) begin
      if (loads - l0 == 2 && cur_stage == 2'd2) break;
      @(negedge CLK);
    end
    chk("pre_reset_jobs_done", jobs_done, 1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("async_reset");
    sb.delete();
    @(negedge CLK);
    rst = 1'b1;
    run_batch(8'd1, 1, 1'b0);

    repeat (3) @(negedge CLK);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
